// File: rtl/grid_scanner.sv
// -----------------------------------------------------------------------------
// grid_scanner
//
// Raster writer that paints a ROWS x COLS bit grid into a pixel framebuffer.
// Each grid cell becomes a CELL_W x CELL_H block of pixels, and one pixel write
// is issued per clock. A frame is requested with start (or kept running with
// continuous). The grid and the invert flag are captured once per frame, so the
// grid logic may keep changing while a frame is being drawn.
//
// Ports
//   clock        system clock, shared with the framebuffer
//   reset_n      asynchronous active-low reset
//   grid_in      cell bits, cell (r,c) = grid_in[r*COLS+c], 1 = lit
//   start        one-frame request, only honoured while idle
//   continuous   keep re-rendering frames back to back while high
//   invert       draw the complement of each cell bit (captured with the grid)
//   x, y         pixel coordinate of the current write
//   pixel_color  pixel value of the current write (0 when not writing)
//   pixel_write  write strobe, high only while drawing
//   busy         high while loading or drawing a frame
//   done         one-cycle pulse after the last pixel of a frame
//
// State table
//   state  | meaning
//   IDLE   | waiting for start or continuous
//   LOAD   | one cycle; grid/invert snapshot taken, raster counters cleared
//   DRAW   | one pixel write per cycle in raster order
//   DONE   | one cycle; done pulse, then LOAD (continuous) or IDLE
// -----------------------------------------------------------------------------
module grid_scanner #(
    parameter int ROWS       = 10,
    parameter int COLS       = 40,
    parameter int CELL_W     = 16,
    parameter int CELL_H     = 48,
    parameter int X_W        = 11,
    parameter int Y_W        = 10,
    parameter int GRID_LINES = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [ROWS*COLS-1:0] grid_in,
    input  logic                 start,
    input  logic                 continuous,
    input  logic                 invert,
    output logic [X_W-1:0]       x,
    output logic [Y_W-1:0]       y,
    output logic                 pixel_color,
    output logic                 pixel_write,
    output logic                 busy,
    output logic                 done
);

    localparam int SX_W = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int SY_W = (CELL_H > 1) ? $clog2(CELL_H) : 1;
    localparam int C_W  = (COLS   > 1) ? $clog2(COLS)   : 1;
    localparam int R_W  = (ROWS   > 1) ? $clog2(ROWS)   : 1;

    localparam logic [SX_W-1:0] SX_MAX = SX_W'(CELL_W - 1);
    localparam logic [SY_W-1:0] SY_MAX = SY_W'(CELL_H - 1);
    localparam logic [C_W-1:0]  C_MAX  = C_W'(COLS - 1);
    localparam logic [R_W-1:0]  R_MAX  = R_W'(ROWS - 1);
    localparam logic [X_W-1:0]  X_MAX  = X_W'(COLS * CELL_W - 1);
    localparam logic [Y_W-1:0]  Y_MAX  = Y_W'(ROWS * CELL_H - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DRAW = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    // Packed [row][col] layout puts cell (r,c) at bit r*COLS+c, so a direct
    // copy of grid_in lines up and the lookup needs no multiplier.
    logic [ROWS-1:0][COLS-1:0] shadow;
    logic                      shadow_inv;

    // Raster position of the next pixel to be emitted.
    logic [SX_W-1:0] sub_x;
    logic [C_W-1:0]  col;
    logic [SY_W-1:0] sub_y;
    logic [R_W-1:0]  row;
    logic [X_W-1:0]  x_cnt;
    logic [Y_W-1:0]  y_cnt;

    // Set when the final pixel of the frame has been emitted.
    logic frame_end;

    logic sx_wrap;
    logic col_wrap;
    logic sy_wrap;
    logic row_wrap;
    logic x_wrap;
    logic y_wrap;
    logic last_px;
    logic cell_bit;
    logic on_line;
    logic color_nx;
    logic load_nx;
    logic draw_nx;

    assign sx_wrap  = (sub_x == SX_MAX);
    assign col_wrap = (col   == C_MAX);
    assign sy_wrap  = (sub_y == SY_MAX);
    assign row_wrap = (row   == R_MAX);
    assign x_wrap   = (x_cnt == X_MAX);
    assign y_wrap   = (y_cnt == Y_MAX);
    assign last_px  = sx_wrap & col_wrap & sy_wrap & row_wrap;

    assign cell_bit = shadow[row][col];
    assign on_line  = (GRID_LINES != 0) && ((sub_x == '0) || (sub_y == '0));
    // Grid lines are forced black even when the frame is inverted.
    assign color_nx = on_line ? 1'b0 : (cell_bit ^ shadow_inv);

    assign load_nx  = (state_nx == S_LOAD);
    assign draw_nx  = (state_nx == S_DRAW);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start || continuous) begin
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                state_nx = S_DRAW;
            end
            S_DRAW: begin
                if (frame_end) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = continuous ? S_LOAD : S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------ snapshot regs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow     <= '0;
            shadow_inv <= 1'b0;
        end else if (load_nx) begin
            shadow     <= grid_in;
            shadow_inv <= invert;
        end
    end

    // ---------------------------------------------------- raster counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sub_x     <= '0;
            col       <= '0;
            sub_y     <= '0;
            row       <= '0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            frame_end <= 1'b0;
        end else if (load_nx) begin
            sub_x     <= '0;
            col       <= '0;
            sub_y     <= '0;
            row       <= '0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            frame_end <= 1'b0;
        end else if (draw_nx) begin
            frame_end <= last_px;

            if (sx_wrap) begin
                sub_x <= '0;
                if (col_wrap) begin
                    col <= '0;
                    if (sy_wrap) begin
                        sub_y <= '0;
                        row   <= row_wrap ? '0 : row + 1'b1;
                    end else begin
                        sub_y <= sub_y + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end else begin
                sub_x <= sub_x + 1'b1;
            end

            if (x_wrap) begin
                x_cnt <= '0;
                y_cnt <= y_wrap ? '0 : y_cnt + 1'b1;
            end else begin
                x_cnt <= x_cnt + 1'b1;
            end
        end
    end

    // ---------------------------------------------------- output registers
    // Outputs are loaded from the next state so they line up with it: the
    // k-th DRAW cycle shows write k, and done/busy match DONE/LOAD/DRAW.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x           <= '0;
            y           <= '0;
            pixel_color <= 1'b0;
            pixel_write <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            pixel_write <= draw_nx;
            busy        <= load_nx || draw_nx;
            done        <= (state_nx == S_DONE);
            pixel_color <= draw_nx ? color_nx : 1'b0;
            if (draw_nx) begin
                x <= x_cnt;
                y <= y_cnt;
            end
        end
    end

endmodule
